// File: rtl/nrr_victim_issuer.sv
// Victim-row issuer: queues aggressor rows and issues neighbour refreshes at
// +/-1..+/-BLAST_RADIUS over valid/ready. Optional NRR_VICTIM_DEDUP_EN drops duplicate aggressors.
module nrr_victim_issuer #(
    parameter int ADDR_SIZE       = 18,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int BLAST_RADIUS    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 nrr_cmd,
    input  logic [ADDR_SIZE-1:0] nrr_addr,
    output logic                 ref_valid,
    output logic [ADDR_SIZE-1:0] ref_addr,
    input  logic                 ref_ready,
    output logic                 busy,
    output logic                 drop_pulse,
    output logic [7:0]           drop_cnt
);
    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [2:0] K_MAX = 3'(BLAST_RADIUS);
    localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);

    state_t                     state, state_nxt;
    logic [ADDR_SIZE-1:0]       mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;
    logic [ADDR_SIZE-1:0]       cur_addr;
    logic [2:0]                 k;
    logic                       side;  // 0: cur_addr-k, 1: cur_addr+k

    logic                       pop, push_ok, dup, drop, full;
    logic [ADDR_SIZE:0]         cand;
    logic                       in_range, advance, last;

    // Candidate is one bit wider so a PLUS overflow is visible instead of wrapping.
    always_comb begin
        if (side) begin
            cand     = {1'b0, cur_addr} + (ADDR_SIZE+1)'(k);
            in_range = ~cand[ADDR_SIZE];
        end else begin
            cand     = {1'b0, cur_addr} - (ADDR_SIZE+1)'(k);
            in_range = (cur_addr >= ADDR_SIZE'(k));
        end
    end

    assign ref_valid = (state == ISSUE) && in_range;
    assign ref_addr  = ref_valid ? cand[ADDR_SIZE-1:0] : '0;
    assign advance   = (state == ISSUE) && (!in_range || ref_ready);
    assign last      = side && (k == K_MAX);
    assign pop       = (state == IDLE) && (count != '0);
    assign full      = (count == FULL_CNT);
    assign busy      = (count != '0) || (state != IDLE);

`ifdef NRR_VICTIM_DEDUP_EN
    logic [FIFO_DEPTH_BITS-1:0] offs;
    always_comb begin
        dup  = 1'b0;
        offs = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offs = FIFO_DEPTH_BITS'(i) - rd_ptr;
            if (({1'b0, offs} < count) && (mem[i] == nrr_addr)) dup = 1'b1;
        end
        if ((state == ISSUE) && (cur_addr == nrr_addr)) dup = 1'b1;
    end
`else
    assign dup = 1'b0;
`endif

    // A full FIFO still accepts when its head is leaving in the same cycle.
    assign push_ok = nrr_cmd && !rst && !dup && (!full || pop);
    assign drop    = nrr_cmd && !rst && !dup && !push_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = ISSUE;
            ISSUE:   if (advance && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= nrr_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cur_addr   <= '0;
            k          <= 3'd1;
            side       <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                cur_addr <= mem[rd_ptr];
                k        <= 3'd1;
                side     <= 1'b0;
            end else if (advance) begin
                if (side) begin
                    side <= 1'b0;
                    k    <= k + 3'd1;
                end else begin
                    side <= 1'b1;
                end
            end
            drop_pulse <= drop;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_nrr_victim_issuer.sv
// Randomized + directed bench for nrr_victim_issuer against a queue-based victim-list model.
module tb_nrr_victim_issuer;
    localparam int MAXA  = 262143;
    localparam int DEPTH = 4;
    localparam int R     = 2;

    typedef struct packed { logic v; logic [17:0] a; } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nrr_cmd = 1'b0;
    logic [17:0] nrr_addr = '0;
    logic        ref_ready = 1'b0;
    logic        ref_valid, busy, drop_pulse;
    logic [17:0] ref_addr;
    logic [7:0]  drop_cnt;

    nrr_victim_issuer dut (
        .clk(clk), .rst(rst), .nrr_cmd(nrr_cmd), .nrr_addr(nrr_addr),
        .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_ready(ref_ready),
        .busy(busy), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int q[$];
    slot_t slots[$];
    bit m_active = 0, m_dp = 0;
    int m_cur = 0, m_dcnt = 0;
    int o_v, o_a, o_busy, o_dp, o_dc, hs = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: drive, compare against model, then advance the model.
    task automatic cyc(input bit c, input int a, input bit rdy, input bit r);
        bit ev, pop, dup, acc;
        int aa;
        @(negedge clk);
        rst = r; nrr_cmd = c; nrr_addr = a[17:0]; ref_ready = rdy;
        #1;
        ev = m_active && slots[0].v;
        chk("ref_valid", int'(ref_valid), int'(ev));
        if (ev) chk("ref_addr", int'(ref_addr), int'(slots[0].a));
        chk("busy", int'(busy), int'(m_active || q.size() != 0));
        chk("drop_pulse", int'(drop_pulse), int'(m_dp));
        chk("drop_cnt", int'(drop_cnt), m_dcnt);
        o_v = int'(ref_valid); o_a = int'(ref_addr); o_busy = int'(busy);
        o_dp = int'(drop_pulse); o_dc = int'(drop_cnt);
        if (ref_valid && rdy) hs++;
        if (r) begin
            q.delete(); slots.delete(); m_active = 0; m_dp = 0; m_dcnt = 0;
        end else begin
            pop = !m_active && q.size() > 0;
            dup = 0;
`ifdef NRR_VICTIM_DEDUP_EN
            if (c) begin
                foreach (q[i]) if (q[i] == a) dup = 1;
                if (m_active && m_cur == a) dup = 1;
            end
`endif
            acc  = c && !dup && (q.size() < DEPTH || pop);
            m_dp = c && !dup && !acc;
            if (m_dp && m_dcnt < 255) m_dcnt++;
            if (m_active) begin
                if (!slots[0].v || rdy) void'(slots.pop_front());
                if (slots.size() == 0) m_active = 0;
            end else if (pop) begin
                m_cur = q.pop_front();
                for (int kk = 1; kk <= R; kk++) begin
                    aa = m_cur - kk;
                    slots.push_back(m_cur >= kk ? slot_t'{1'b1, aa[17:0]} : slot_t'{1'b0, 18'd0});
                    aa = m_cur + kk;
                    slots.push_back(aa <= MAXA ? slot_t'{1'b1, aa[17:0]} : slot_t'{1'b0, 18'd0});
                end
                m_active = 1;
            end
            if (acc) q.push_back(a);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, rdy, 0);
    endtask

    initial begin
        int exp4[4];
        int h0, pk, ad;

        repeat (3) @(posedge clk);
        // Reset state (model starts cleared)
        cyc(0, 0, 1, 0);
        chk("rst_valid", o_v, 0); chk("rst_addr", o_a, 0); chk("rst_busy", o_busy, 0);
        chk("rst_dp", o_dp, 0); chk("rst_dc", o_dc, 0);

        // Single aggressor 100
        cyc(0, 0, 1, 1);
        cyc(1, 100, 1, 0); idle(1, 1);
        exp4 = '{99, 101, 98, 102};
        for (int i = 0; i < 4; i++) begin idle(1, 1); chk("s1_addr", o_a, exp4[i]); end
        idle(1, 1); chk("s1_busy_fall", o_busy, 0);
        idle(2, 1);

        // Low edge
        cyc(0, 0, 1, 1);
        cyc(1, 0, 1, 0); idle(1, 1);
        idle(1, 1); chk("lo_skip2", o_v, 0);
        idle(1, 1); chk("lo_c3", o_a, 1);
        idle(1, 1); chk("lo_skip4", o_v, 0);
        idle(1, 1); chk("lo_c5", o_a, 2);
        idle(2, 1);

        // High edge
        cyc(0, 0, 1, 1);
        cyc(1, MAXA, 1, 0); idle(1, 1);
        idle(1, 1); chk("hi_c2", o_a, 262142);
        idle(1, 1); chk("hi_skip3", o_v, 0);
        idle(1, 1); chk("hi_c4", o_a, 262141);
        idle(1, 1); chk("hi_skip5", o_v, 0);
        idle(2, 1);

        // Backpressure
        cyc(0, 0, 1, 1);
        cyc(1, 50, 1, 0); idle(1, 1);
        idle(3, 0);
        idle(1, 1); chk("bp_c5_v", o_v, 1); chk("bp_c5_a", o_a, 49);
        idle(1, 1); chk("bp_c6", o_a, 51);
        idle(1, 1); chk("bp_c7", o_a, 48);
        idle(1, 1); chk("bp_c8", o_a, 52);
        idle(2, 1);

        // Overflow
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 6; i++) cyc(1, 10 + i, 0, 0);
        cyc(0, 0, 0, 0); chk("ov_dp", o_dp, 1); chk("ov_dc", o_dc, 1);
        idle(30, 1);

        // Duplicate aggressors
        cyc(0, 0, 1, 1);
        h0 = hs;
        cyc(1, 20, 1, 0); cyc(1, 20, 1, 0); cyc(1, 30, 1, 0);
        idle(25, 1);
`ifdef NRR_VICTIM_DEDUP_EN
        chk("dedup_victims", hs - h0, 8);
`else
        chk("dedup_victims", hs - h0, 12);
`endif
        chk("dedup_dc", o_dc, 0);

        // Reset mid-ISSUE
        cyc(0, 0, 1, 1);
        cyc(1, 100, 1, 0); cyc(1, 200, 1, 0); cyc(1, 300, 1, 0);
        cyc(0, 0, 1, 1);
        idle(1, 1); chk("rmid_valid", o_v, 0); chk("rmid_busy", o_busy, 0);
        h0 = hs;
        idle(10, 1); chk("rmid_quiet", hs - h0, 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            pk = $urandom_range(0, 9);
            case (pk)
                0: ad = 0;
                1: ad = 1;
                2: ad = MAXA;
                3: ad = MAXA - 1;
                default: ad = 1000 + $urandom_range(0, 7);
            endcase
            cyc($urandom_range(0, 99) < 40, ad, $urandom_range(0, 99) < 70,
                $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/nrr_victim_issuer.md
# nrr_victim_issuer

Downstream consumer of the per-bank RFM tracking unit. Buffers each aggressor row the tracker reports on `nrr_cmd`/`nrr_addr` and expands it into neighbour-row refreshes: victims at ±1..±BLAST_RADIUS. Issues the victims one at a time over a valid/ready handshake to the DRAM command scheduler. Bounds the number of pending aggressors and reports any it drops.

## Interface
- `ADDR_SIZE`, 18, row address width; must match the tracker.
- `FIFO_DEPTH`, 4, number of pending aggressor entries.
- `FIFO_DEPTH_BITS`, 2, log2(FIFO_DEPTH).
- `BLAST_RADIUS`, 2, victims per side; range 1..7.

One clock. Reset is synchronous and active-high.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `nrr_cmd` in 1: one-cycle pulse; aggressor report from the tracker.
- `nrr_addr` in ADDR_SIZE: aggressor row; valid with `nrr_cmd`.
- `ref_valid` out 1: victim refresh request.
- `ref_addr` out ADDR_SIZE: victim row.
- `ref_ready` in 1: scheduler accepts the victim.
- `busy` out 1: high when the FIFO is non-empty or the FSM is not IDLE.
- `drop_pulse` out 1: one-cycle pulse when an aggressor is discarded.
- `drop_cnt` out 8: saturating count of discarded aggressors.

## Operation
- FIFO: circular buffer with FIFO_DEPTH entries, plus a count of FIFO_DEPTH_BITS+1 bits. Read and write pointers wrap modulo FIFO_DEPTH.
- Push: on a cycle with `nrr_cmd`=1. The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Drop: a push that is not accepted discards the new aggressor.
  - `drop_pulse`=1 for that cycle.
  - `drop_cnt` increments and saturates at 255.
  - FIFO contents are unchanged.
- FSM states: IDLE, ISSUE.
- IDLE:
  - If the FIFO is non-empty: pop the head into `cur_addr`, set k=1, set side=MINUS, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: the candidate is `cur_addr-k` when side=MINUS, or `cur_addr+k` when side=PLUS.
  - Compute the candidate in ADDR_SIZE+1 bits.
  - MINUS is in range if `cur_addr` >= k.
  - PLUS is in range if `cur_addr+k` <= 2^ADDR_SIZE-1.
  - Out-of-range candidate: skip it. The skip consumes one cycle with `ref_valid`=0. No wrap-around.
  - In-range candidate: drive `ref_valid`=1 and `ref_addr`=candidate. Hold both until a cycle with `ref_ready`=1.
- Advance (after an accepted or skipped candidate):
  - MINUS goes to PLUS with the same k.
  - PLUS goes to MINUS with k+1.
  - After PLUS with k=BLAST_RADIUS, return to IDLE.
- Issue order per aggressor A: A-1, A+1, A-2, A+2, …, A-BLAST_RADIUS, A+BLAST_RADIUS.
- Aggressors are serviced in FIFO arrival order.
- Reset outputs, effective on the edge where `rst`=1: `ref_valid`=0, `ref_addr`=0, `busy`=0, `drop_pulse`=0, `drop_cnt`=0. Also: FIFO empty, pointers=0, state=IDLE.
- Reset mid-operation abandons the in-service aggressor and all queued entries. Nothing is replayed.
- `nrr_cmd` while `rst`=1 is ignored.

## Timing
- `nrr_cmd` in cycle T with an empty FIFO and the FSM in IDLE:
  - Entry written at the end of T.
  - Popped at the end of T+1.
  - First `ref_valid` in T+2.
- With `ref_ready` held at 1 and no skips, one victim issues per cycle. 2·BLAST_RADIUS victims occupy cycles T+2..T+1+2·BLAST_RADIUS.
- Between aggressors, the IDLE pop cycle adds one bubble (`ref_valid`=0).
- `ref_valid` never drops and `ref_addr` never changes while waiting for `ref_ready`.
- The handshake completes in any cycle where `ref_valid`&`ref_ready`=1.
- `drop_pulse` is registered: high in the cycle after the rejected `nrr_cmd` cycle.
- `drop_cnt` updates on that same edge.

## Configuration
- `NRR_VICTIM_DEDUP_EN` defined:
  - An incoming `nrr_addr` is discarded silently if it equals any valid FIFO entry or the in-service `cur_addr` while in ISSUE.
  - A dedup discard does not raise `drop_pulse` and does not change `drop_cnt`.
- `NRR_VICTIM_DEDUP_EN` undefined:
  - No comparison is made; duplicates are queued and re-issued.

## Test plan
- Single aggressor at defaults: `nrr_cmd` with `nrr_addr`=100 in cycle 0, `ref_ready`=1 → `ref_addr` 99, 101, 98, 102 in cycles 2–5. `busy` falls in cycle 6.
- Low edge: `nrr_addr`=0 in cycle 0, `ref_ready`=1:
  - `ref_valid`=0 in cycles 2 and 4 (skips).
  - `ref_addr`=1 in cycle 3 and `ref_addr`=2 in cycle 5.
  - Mirror case: `nrr_addr`=262143 gives 262142 in cycle 2 and 262141 in cycle 4, with skips in cycles 3 and 5.
- Backpressure: `nrr_addr`=50, `ref_ready`=0 for cycles 2–4 → `ref_valid`=1 with `ref_addr`=49 held through cycles 2–5. After that, 51, 48, 52 in cycles 6–8.
- Overflow: `nrr_cmd` in cycles 0–5 with addrs 10..15 and `ref_ready`=0 (in that cycle range) → 10 is in service, 11–14 are queued, 15 is dropped. `drop_pulse`=1 in cycle 6 and `drop_cnt`=1.
- Dedup, with `NRR_VICTIM_DEDUP_EN`: addrs 20, 20, 30 in cycles 0–2 → the victim sequence is 19, 21, 18, 22, then 29, 31, 28, 32, and `drop_cnt`=0. Without the macro, the 20-sequence appears twice.
- Reset mid-ISSUE: `rst`=1 in cycle 3 of the single-aggressor test with 2 entries queued → `ref_valid`=0 from cycle 4. `busy`=0 and no further victims until a new `nrr_cmd`.
